// File: rtl/fft_bitrev_buffer.sv
// Ping-pong reorder buffer: collects N natural-order samples per bank and replays each packet
// in bit-reversed order. Optional natural-order replay via `FFT_BITREV_BYPASS_EN (adds port bypass).
module fft_bitrev_buffer #(
    parameter int Q_IN  = 15,
    parameter int N     = 8,
    parameter int LOG2N = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          valid_in,
    output logic          ready_out,
    input  logic [Q_IN:0] data_in_real,
    output logic          valid_out,
    input  logic          ready_in,
    output logic [3:0]    addr_out,
    output logic [Q_IN:0] data_out_real,
    output logic          last_out
`ifdef FFT_BITREV_BYPASS_EN
    ,
    input  logic          bypass
`endif
);

    localparam logic [0:0]       S_IDLE = 1'b0;
    localparam logic [0:0]       S_SEND = 1'b1;
    localparam logic [LOG2N-1:0] K_LAST = LOG2N'(N - 1);

    logic signed [Q_IN:0] mem_q [2][N];

    logic             rdy_en_q;
    logic             wr_bank_q, wr_bank_d;
    logic             rd_bank_q, rd_bank_d;
    logic [1:0]       full_q, full_d;
    logic [1:0]       set_full, clr_full;
    logic [LOG2N-1:0] wcnt_q, wcnt_d;
    logic [LOG2N-1:0] rcnt_q, rcnt_d;
    logic [0:0]       state_q, state_d;
    logic             valid_q, valid_d;
    logic signed [Q_IN:0] data_q, data_d;
    logic [3:0]       addr_q, addr_d;
    logic             last_q, last_d;
    logic             byp_q, byp_d;
    logic             byp_start;
    logic             wr_en;
    logic [LOG2N-1:0] k_next;

`ifdef FFT_BITREV_BYPASS_EN
    assign byp_start = bypass;
`else
    assign byp_start = 1'b0;
`endif

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] k);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = k[LOG2N-1-i];
        end
        return r;
    endfunction

    function automatic logic [LOG2N-1:0] rd_index(input logic [LOG2N-1:0] k, input logic nat);
        return nat ? k : bitrev(k);
    endfunction

    // ready_out is forced low until the first clock after reset release.
    assign ready_out = rdy_en_q && !full_q[wr_bank_q];
    assign wr_en     = valid_in && ready_out;

    assign valid_out     = valid_q;
    assign data_out_real = data_q;
    assign addr_out      = addr_q;
    assign last_out      = last_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_bank_q][wcnt_q] <= signed'(data_in_real);
        end
    end

    always_comb begin
        wcnt_d    = wcnt_q;
        wr_bank_d = wr_bank_q;
        set_full  = 2'b00;
        if (wr_en) begin
            if (wcnt_q == K_LAST) begin
                wcnt_d              = '0;
                wr_bank_d           = ~wr_bank_q;
                set_full[wr_bank_q] = 1'b1;
            end else begin
                wcnt_d = wcnt_q + 1'b1;
            end
        end
    end

    assign k_next = rcnt_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        rcnt_d    = rcnt_q;
        rd_bank_d = rd_bank_q;
        valid_d   = valid_q;
        data_d    = data_q;
        addr_d    = addr_q;
        last_d    = last_q;
        byp_d     = byp_q;
        clr_full  = 2'b00;
        case (state_q)
            S_IDLE: begin
                if (full_q[rd_bank_q]) begin
                    state_d = S_SEND;
                    rcnt_d  = '0;
                    valid_d = 1'b1;
                    byp_d   = byp_start;
                    data_d  = mem_q[rd_bank_q][rd_index('0, byp_start)];
                    addr_d  = '0;
                    last_d  = 1'b0;
                end
            end
            default: begin
                if (valid_q && ready_in) begin
                    if (rcnt_q != K_LAST) begin
                        rcnt_d = k_next;
                        data_d = mem_q[rd_bank_q][rd_index(k_next, byp_q)];
                        addr_d = 4'(k_next);
                        last_d = (k_next == K_LAST);
                    end else begin
                        clr_full[rd_bank_q] = 1'b1;
                        rd_bank_d           = ~rd_bank_q;
                        // Other bank already complete: start it on the very next beat.
                        if (full_q[~rd_bank_q]) begin
                            rcnt_d = '0;
                            byp_d  = byp_start;
                            data_d = mem_q[~rd_bank_q][rd_index('0, byp_start)];
                            addr_d = '0;
                            last_d = 1'b0;
                        end else begin
                            state_d = S_IDLE;
                            valid_d = 1'b0;
                        end
                    end
                end
            end
        endcase
    end

    assign full_d = (full_q & ~clr_full) | set_full;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdy_en_q  <= 1'b0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            full_q    <= 2'b00;
            wcnt_q    <= '0;
            rcnt_q    <= '0;
            state_q   <= S_IDLE;
            valid_q   <= 1'b0;
            data_q    <= '0;
            addr_q    <= '0;
            last_q    <= 1'b0;
            byp_q     <= 1'b0;
        end else begin
            rdy_en_q  <= 1'b1;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            full_q    <= full_d;
            wcnt_q    <= wcnt_d;
            rcnt_q    <= rcnt_d;
            state_q   <= state_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            addr_q    <= addr_d;
            last_q    <= last_d;
            byp_q     <= byp_d;
        end
    end

endmodule
